// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared constants and state encoding for the cache-side
//               line <-> memory-side burst adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Address, line and beat geometry
  localparam int s_addr         = 32;
  localparam int s_offset       = 5;
  localparam int s_line         = 256;
  localparam int s_burst        = 64;
  localparam int beats_per_line = s_line / s_burst;
  localparam int cnt_w          = $clog2(beats_per_line);

  // Adapter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter
// Description : Splits 256-bit cache line fills/writebacks into four 64-bit
//               memory beats (lowest address first) and reassembles fills.
//               One transaction in flight; outputs decode registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adapter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  // cache side
  input  logic [s_addr-1:0]   line_addr,
  input  logic                line_read,
  input  logic                line_write,
  input  logic [s_line-1:0]   line_wdata,
  output logic [s_line-1:0]   line_rdata,
  output logic                line_resp,
  // memory side
  output logic [s_addr-1:0]   burst_addr,
  output logic                burst_read,
  output logic                burst_write,
  output logic [s_burst-1:0]  burst_wdata,
  input  logic [s_burst-1:0]  burst_rdata,
  input  logic                burst_resp
);

  localparam logic [cnt_w-1:0] c_last_beat = cnt_w'(beats_per_line - 1);

  adapter_state_t      r_state, w_state_nxt;
  logic [cnt_w-1:0]    r_cnt, w_cnt_nxt;
  logic [s_addr-1:0]   r_addr, w_addr_nxt;
  logic [s_line-1:0]   r_wline, w_wline_nxt;
  logic [s_line-1:0]   r_rline, w_rline_nxt;
  logic [s_addr-1:0]   w_aligned_addr;
  logic                w_last_beat;
  logic                w_unused;

  // Byte-offset bits of the request address are deliberately discarded.
  assign w_aligned_addr = {line_addr[s_addr-1:s_offset], {s_offset{1'b0}}};
  assign w_unused       = &{1'b0, line_addr[s_offset-1:0]};
  assign w_last_beat    = (r_cnt == c_last_beat);

  // Next-state, beat counter and data-path update decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_wline_nxt = r_wline;
    w_rline_nxt = r_rline;
    case (r_state)
      IDLE: begin
        // A simultaneous read and write is illegal from the cache; read wins.
        if (line_read) begin
          w_state_nxt = READ;
          w_addr_nxt  = w_aligned_addr;
          w_cnt_nxt   = '0;
        end else if (line_write) begin
          w_state_nxt = WRITE;
          w_addr_nxt  = w_aligned_addr;
          w_wline_nxt = line_wdata;
          w_cnt_nxt   = '0;
        end
      end
      READ: begin
        if (burst_resp) begin
          w_rline_nxt[r_cnt*s_burst +: s_burst] = burst_rdata;
          if (w_last_beat) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      WRITE: begin
        if (burst_resp) begin
          if (w_last_beat) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and data-path registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rline <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_wline <= w_wline_nxt;
      r_rline <= w_rline_nxt;
    end
  end

  // Outputs decoded purely from registered state.
  assign line_rdata  = r_rline;
  assign line_resp   = (r_state == DONE);
  assign burst_read  = (r_state == READ);
  assign burst_write = (r_state == WRITE);
  assign burst_addr  = (burst_read || burst_write) ? r_addr : '0;
  assign burst_wdata = burst_write ? r_wline[r_cnt*s_burst +: s_burst] : '0;

endmodule : cacheline_adapter
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adapter
// Description : Self-checking bench for cacheline_adapter: a vector table of
//               line transactions driven against a simple memory model, with
//               fill lines and write beats checked through scoreboard queues,
//               plus a hand-written reset-mid-burst sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [s_addr-1:0]  line_addr = '0;
  logic               line_read = 1'b0;
  logic               line_write = 1'b0;
  logic [s_line-1:0]  line_wdata = '0;
  logic [s_line-1:0]  line_rdata;
  logic               line_resp;
  logic [s_addr-1:0]  burst_addr;
  logic               burst_read;
  logic               burst_write;
  logic [s_burst-1:0] burst_wdata;
  logic [s_burst-1:0] burst_rdata = '0;
  logic               burst_resp = 1'b0;

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .line_addr   (line_addr),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_addr  (burst_addr),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_wdata (burst_wdata),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [255:0] data;        // memory beats returned for reads
    logic [255:0] wline;       // line offered for writeback
    logic [3:0][3:0] stall;    // idle cycles before each beat
    logic [31:0] exp_addr;
    logic        exp_write;
    int          exp_lat;      // request cycle to line_resp cycle
  } vec_t;

  vec_t vecs[5];
  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [255:0] last_fill = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one line request and play the memory side until line_resp.
  task automatic run_txn(input vec_t v);
    int cyc;
    int beat;
    int stalled;
    bit done;
    logic [63:0] eb;
    line_addr  = v.addr;
    line_read  = v.rd;
    line_write = v.wr;
    line_wdata = v.wline;
    burst_resp = 1'b0;
    if (v.exp_write) begin
      for (int i = 0; i < 4; i++) exp_beat_q.push_back(v.wline[i*64 +: 64]);
    end else begin
      exp_line_q.push_back(v.data);
    end
    cyc = 0; beat = 0; stalled = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("idle_before_accept", {line_resp, burst_read, burst_write}, 3'b000);
      end else if (line_resp) begin
        check("latency", cyc, v.exp_lat);
        check("resp_no_burst", {burst_read, burst_write}, 2'b00);
        if (!v.exp_write) begin
          if (exp_line_q.size() > 0) check("line_rdata", line_rdata, exp_line_q.pop_front());
          else check("fill_scoreboard_empty", 1, 0);
          last_fill = v.data;
        end else begin
          check("rdata_hold", line_rdata, last_fill);
        end
        done = 1;
      end else begin
        check("burst_rw", {burst_read, burst_write}, v.exp_write ? 2'b01 : 2'b10);
        check("burst_addr", burst_addr, v.exp_addr);
        if (v.exp_write) begin
          eb = (exp_beat_q.size() > 0) ? exp_beat_q[0] : 64'hx;
          check("burst_wdata", burst_wdata, eb);
        end
        if (beat < 4 && stalled < int'(v.stall[beat])) begin
          burst_resp = 1'b0;
          stalled++;
        end else if (beat < 4) begin
          burst_resp  = 1'b1;
          burst_rdata = v.data[beat*64 +: 64];
          if (v.exp_write && exp_beat_q.size() > 0) void'(exp_beat_q.pop_front());
          beat++;
          stalled = 0;
        end else begin
          burst_resp = 1'b0;
        end
      end
      if (!done && cyc >= 100) begin
        check("timeout_waiting_line_resp", 0, 1);
        done = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    // Cache drops its request the cycle after line_resp.
    line_read  = 1'b0;
    line_write = 1'b0;
    burst_resp = 1'b0;
  endtask

  initial begin
    logic [255:0] wl;
    int cyc;

    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234,
                data: {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}},
                wline: '0, stall: '0, exp_addr: 32'h0000_1220, exp_write: 1'b0, exp_lat: 5};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_00E0,
                data: {4{64'hFFFF_0000_FFFF_0000}},
                wline: {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}},
                stall: '0, exp_addr: 32'h0000_00E0, exp_write: 1'b1, exp_lat: 5};
    vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'hABCD_EF7F,
                data: {64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
                       64'h1357_9BDF_0246_8ACE, 64'hDEAD_BEEF_CAFE_F00D},
                wline: '0, stall: {4'd3, 4'd0, 4'd3, 4'd0},
                exp_addr: 32'hABCD_EF60, exp_write: 1'b0, exp_lat: 11};
    vecs[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_0040,
                data: {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                       64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
                wline: {4{64'h5A5A_5A5A_5A5A_5A5A}}, stall: '0,
                exp_addr: 32'h0000_0040, exp_write: 1'b0, exp_lat: 5};
    vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: 32'h8000_001F, data: '0,
                wline: {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                        64'h0123_4567_89AB_CDEF, 64'hFEED_FACE_0BAD_CAFE},
                stall: {4'd0, 4'd2, 4'd1, 4'd0},
                exp_addr: 32'h8000_0000, exp_write: 1'b1, exp_lat: 8};

    // Reset values, checked while reset is held.
    #2;
    check("reset_outputs", {line_resp, burst_read, burst_write, burst_addr, burst_wdata}, '0);
    check("reset_line_rdata", line_rdata, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table: back-to-back transactions, request dropped after line_resp.
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // No duplicate transaction once requests are dropped.
    repeat (3) begin
      @(negedge clk);
      check("idle_after_table", {line_resp, burst_read, burst_write}, 3'b000);
    end

    // Reset asserted while write beat 2 is on the bus.
    @(posedge clk);
    #1;
    wl = {64'hD2D2_D2D2_D2D2_D2D2, 64'hC2C2_C2C2_C2C2_C2C2,
          64'hB2B2_B2B2_B2B2_B2B2, 64'hA2A2_A2A2_A2A2_A2A2};
    line_addr  = 32'h0000_0100;
    line_write = 1'b1;
    line_wdata = wl;
    for (cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc >= 1) burst_resp = 1'b1;
      if (cyc < 3) begin
        @(posedge clk);
        #1;
      end
    end
    check("rst_pre_beat2", burst_wdata, wl[128 +: 64]);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", {line_resp, burst_read, burst_write, burst_addr, burst_wdata}, '0);
    check("rst_mid_line_rdata", line_rdata, '0);
    last_fill  = '0;
    line_write = 1'b0;
    burst_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", {line_resp, burst_read, burst_write}, 3'b000);
    end
    @(posedge clk);
    #1;
    run_txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cacheline_adapter
`default_nettype wire

// File: doc/cacheline_adapter.md
# cacheline_adapter

Converts the cache's single-transaction 256-bit line requests into four-beat 64-bit bursts for main memory, and assembles returned beats back into a line. Sits directly downstream of the cache's memory-side controller port and upstream of the physical memory model/controller. Handles one line transaction at a time, with a fixed beat order and a full handshake on both sides.

## Interface
- s_addr, 32, address width
- s_offset, 5, byte-offset bits within a line (line = 2**s_offset bytes)
- s_line, 256, line width in bits
- s_burst, 64, beat width in bits; s_line/s_burst = 4 beats
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- line_addr  in  s_addr  line request address from cache (offset bits ignored)
- line_read  in  1  line fill request
- line_write  in  1  line writeback request
- line_wdata  in  s_line  writeback line
- line_rdata  out  s_line  assembled fill line
- line_resp  out  1  one-cycle completion pulse to cache
- burst_addr  out  s_addr  line-aligned burst address
- burst_read  out  1  burst read request to memory
- burst_write  out  1  burst write request to memory
- burst_wdata  out  s_burst  current write beat
- burst_rdata  in  s_burst  current read beat
- burst_resp  in  1  memory beat acknowledge (one per beat)

## Operation
- States: IDLE, READ, WRITE, DONE; 2-bit beat counter cnt.
- IDLE: if line_read → latch addr, cnt=0, go READ; else if line_write → latch addr and line_wdata, cnt=0, go WRITE. Both asserted: read wins (illegal from cache; no error flag).
- Latched address = {line_addr[s_addr-1:s_offset], s_offset'b0}; driven on burst_addr in READ/WRITE, 0 otherwise.
- READ: burst_read=1. Each cycle with burst_resp=1: store burst_rdata into line_rdata[cnt*64 +: 64], cnt++. On beat 3 → DONE.
- WRITE: burst_write=1, burst_wdata = latched line[cnt*64 +: 64]. Each burst_resp advances cnt; beat 3 ack → DONE.
- burst_resp=0 in READ/WRITE: hold state, outputs, cnt (unbounded stall).
- DONE: line_resp=1 for exactly one cycle, burst_read/write=0, → IDLE.
- line_rdata holds the last completed fill until the next fill overwrites it beat-by-beat; valid in the DONE cycle.
- Requester inputs are sampled only at IDLE accept; changes during a transaction are ignored. Cache drops its request the cycle after line_resp; IDLE re-accepts only if still asserted then.
- burst_resp in IDLE/DONE: ignored.
- Beat order fixed 0,1,2,3 (lowest address first); cnt wraps 3→0 only via DONE/accept.

## Timing
- Reset (rst=0, immediate): state IDLE, cnt=0, line_resp=0, burst_read=0, burst_write=0, burst_addr=0, burst_wdata=0, line_rdata=0, latched line=0.
- Reset mid-burst: transaction aborted, no line_resp; requests deassert same instant.
- Accept at edge T; burst_read/burst_write high from T+1.
- Zero-wait memory (burst_resp every cycle from T+1): beats at T+1..T+4, line_resp at T+5, back in IDLE at T+6. Minimum latency 5 cycles accept-to-resp; each stall cycle adds one.
- Back-to-back: earliest next accept at T+6.
- All outputs registered or decoded from registered state only; no combinational input→output path.

## Structure
- Shared package cache_pkg: s_addr/s_offset/s_line/s_burst constants, beats_per_line = s_line/s_burst, adapter state enum (IDLE, READ, WRITE, DONE).
- Single module; no sub-module. Line buffer (fill) and write-line latch are separate s_line registers.

## Test plan
- Read, zero-wait: line_addr=0x0000_1234, line_read=1; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → burst_addr=0x0000_1220, line_resp at T+5, line_rdata = {0x44..,0x33..,0x22..,0x11..}.
- Write, zero-wait: line_addr=0x0000_00E0, line_wdata=0xDDDD..CCCC..BBBB..AAAA → burst_wdata sequence 0xAAAA..,0xBBBB..,0xCCCC..,0xDDDD.., burst_write high 4 cycles, line_resp at T+5.
- Stalled read: burst_resp withheld 3 cycles before beats 1 and 3 → line_resp at T+11, beat data unchanged, cnt held during stalls.
- Simultaneous line_read=1 and line_write=1 → READ taken, burst_write never asserted.
- rst low during beat 2 of a write → all outputs 0 immediately, no line_resp; after release, new read completes normally.
- Back-to-back read then write with request dropped after line_resp → second accept at T+6, no duplicate transaction.
